// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state encodings, instruction classes,
// error-cause record and the decoder-flag classifier.
package control_sequencer_pkg;

    localparam int STATE_W          = 3;
    localparam int MEM_WAIT_MAX_DEF = 15;
    localparam int WAIT_W_DEF       = 4;

    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] ST_WB     = 3'd4;
    localparam logic [STATE_W-1:0] ST_ERR    = 3'd7;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_PUSH = 3'd4,
        CLS_POP  = 3'd5,
        CLS_JUMP = 3'd6,
        CLS_BE   = 3'd7
    } cls_e;

    typedef struct packed {
        logic timeout;
        logic illegal;
    } cause_t;

    // Flag vector order is {be, jump, pop, push, st, ld, alu}; anything not one-hot maps to NONE.
    function automatic cls_e encode_class(input logic [6:0] flags);
        cls_e c;
        c = CLS_NONE;
        case (flags)
            7'b000_0001: c = CLS_ALU;
            7'b000_0010: c = CLS_LD;
            7'b000_0100: c = CLS_ST;
            7'b000_1000: c = CLS_PUSH;
            7'b001_0000: c = CLS_POP;
            7'b010_0000: c = CLS_JUMP;
            7'b100_0000: c = CLS_BE;
            default:     c = CLS_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Decoder/datapath/memory handshake bundle of the control sequencer.
// master = sequencer side, slave = datapath/decoder side.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic                alu, ld, st, push, pop, jump, be;
    logic                zero;
    logic                mem_ready;
    logic [STATE_W-1:0]  state;
    logic                mem_req, mem_we;
    logic                ir_load, pc_inc, pc_load;
    logic                sp_dec, sp_inc;
    logic                reg_we;
    logic                illegal, timeout;

    modport master (
        input  alu, ld, st, push, pop, jump, be, zero, mem_ready,
        output state, mem_req, mem_we, ir_load, pc_inc, pc_load,
               sp_dec, sp_inc, reg_we, illegal, timeout
    );

    modport slave (
        output alu, ld, st, push, pop, jump, be, zero, mem_ready,
        input  state, mem_req, mem_we, ir_load, pc_inc, pc_load,
               sp_dec, sp_inc, reg_we, illegal, timeout
    );
endinterface

// File: rtl/control_sequencer_mem_wait_timer.sv
// Memory wait-state counter: counts stalled cycles and flags the cycle whose stall
// would bring the count to MEM_WAIT_MAX.
module control_sequencer_mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [WAIT_W-1:0] LAST_OK = WAIT_W'(MEM_WAIT_MAX - 1);

    logic [WAIT_W-1:0] r_cnt;

    // Stall counter; clear has priority over count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {WAIT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {WAIT_W{1'b0}};
        end else if (i_en) begin
            r_cnt <= r_cnt + WAIT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = i_en & (r_cnt == LAST_OK);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB instruction sequencer with illegal-decode and
// memory-timeout trapping through a one-cycle ERR state.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
    parameter int WAIT_W       = WAIT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_sequencer_if.master  bus
);

    logic [STATE_W-1:0] r_state, w_next_state;
    cls_e               r_cls, w_next_cls, w_dec_cls;
    cause_t             r_cause, w_next_cause;
    logic               w_in_mem, w_wait_clr, w_wait_en, w_expire;

    assign w_dec_cls  = encode_class({bus.be, bus.jump, bus.pop, bus.push, bus.st, bus.ld, bus.alu});
    assign w_in_mem   = (r_state == ST_FETCH) | (r_state == ST_MEM);
    assign w_wait_clr = ~w_in_mem | bus.mem_ready;
    assign w_wait_en  = w_in_mem & ~bus.mem_ready;

    control_sequencer_mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .WAIT_W       (WAIT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_wait_clr),
        .i_en     (w_wait_en),
        .o_expire (w_expire)
    );

    // Next-state, class latch and error-cause logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cls   = r_cls;
        w_next_cause = r_cause;
        case (r_state)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    w_next_state = ST_DECODE;
                end else if (w_expire) begin
                    w_next_state         = ST_ERR;
                    w_next_cause.timeout = 1'b1;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                w_next_cls = w_dec_cls;
                if (w_dec_cls == CLS_NONE) begin
                    w_next_state         = ST_ERR;
                    w_next_cause.illegal = 1'b1;
                end else if (w_dec_cls == CLS_POP) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (r_cls)
                    CLS_ALU:                   w_next_state = ST_WB;
                    CLS_LD, CLS_ST, CLS_PUSH:  w_next_state = ST_MEM;
                    default:                   w_next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    if ((r_cls == CLS_LD) || (r_cls == CLS_POP)) begin
                        w_next_state = ST_WB;
                    end else begin
                        w_next_state = ST_FETCH;
                    end
                end else if (w_expire) begin
                    w_next_state         = ST_ERR;
                    w_next_cause.timeout = 1'b1;
                end else begin
                    w_next_state = ST_MEM;
                end
            end
            ST_WB: begin
                w_next_state = ST_FETCH;
            end
            ST_ERR: begin
                w_next_state = ST_FETCH;
                w_next_cause = 2'b00;
            end
            default: begin
                w_next_state = ST_FETCH;
                w_next_cause = 2'b00;
            end
        endcase
    end

    // State, class and cause registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_cls   <= CLS_NONE;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next_state;
            r_cls   <= w_next_cls;
            r_cause <= w_next_cause;
        end
    end

    // Strobes are qualified by rst_n so they drop the instant reset asserts.
    assign bus.state   = r_state;
    assign bus.mem_req = rst_n & w_in_mem;
    assign bus.mem_we  = rst_n & (r_state == ST_MEM) & ((r_cls == CLS_ST) | (r_cls == CLS_PUSH));
    assign bus.ir_load = rst_n & (r_state == ST_FETCH) & bus.mem_ready;
    assign bus.pc_inc  = rst_n & (r_state == ST_FETCH) & bus.mem_ready;
    assign bus.pc_load = rst_n & (r_state == ST_EXEC)
                         & ((r_cls == CLS_JUMP) | ((r_cls == CLS_BE) & bus.zero));
    assign bus.sp_dec  = rst_n & (r_state == ST_EXEC) & (r_cls == CLS_PUSH);
    assign bus.sp_inc  = rst_n & (r_state == ST_WB) & (r_cls == CLS_POP);
    assign bus.reg_we  = rst_n & (r_state == ST_WB);
    assign bus.illegal = rst_n & (r_state == ST_ERR) & r_cause.illegal;
    assign bus.timeout = rst_n & (r_state == ST_ERR) & r_cause.timeout;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed and random instructions expanded into an expected
// per-cycle trace from the class/latency rules, compared against the sequencer.
module tb_control_sequencer;

    localparam int WAIT_LIMIT = 15;

    localparam logic [6:0] F_ALU  = 7'b000_0001;
    localparam logic [6:0] F_LD   = 7'b000_0010;
    localparam logic [6:0] F_ST   = 7'b000_0100;
    localparam logic [6:0] F_PUSH = 7'b000_1000;
    localparam logic [6:0] F_POP  = 7'b001_0000;
    localparam logic [6:0] F_JUMP = 7'b010_0000;
    localparam logic [6:0] F_BE   = 7'b100_0000;

    localparam logic [9:0] S_NONE = 10'b00_0000_0000;
    localparam logic [9:0] S_MREQ = 10'b10_0000_0000;
    localparam logic [9:0] S_WE   = 10'b01_0000_0000;
    localparam logic [9:0] S_IRL  = 10'b00_1000_0000;
    localparam logic [9:0] S_PCI  = 10'b00_0100_0000;
    localparam logic [9:0] S_PCL  = 10'b00_0010_0000;
    localparam logic [9:0] S_SPD  = 10'b00_0001_0000;
    localparam logic [9:0] S_SPI  = 10'b00_0000_1000;
    localparam logic [9:0] S_RWE  = 10'b00_0000_0100;
    localparam logic [9:0] S_ILL  = 10'b00_0000_0010;
    localparam logic [9:0] S_TO   = 10'b00_0000_0001;

    typedef struct {
        logic [2:0] st;
        logic [9:0] strb;
        logic       rdy;
        logic       z;
        logic [6:0] fl;
    } cyc_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    cyc_t q[$];

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [2:0] st, input logic [9:0] strb, input logic rdy,
                                input logic z, input logic [6:0] fl);
        cyc_t e;
        e.st = st; e.strb = strb; e.rdy = rdy; e.z = z; e.fl = fl;
        q.push_back(e);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    // A FETCH or MEM transfer with 'waits' stalled cycles; returns 1 if it ends in a timeout trap.
    function automatic bit mem_phase(input logic [2:0] st, input int waits, input logic we);
        logic [9:0] base;
        base = S_MREQ | (we ? S_WE : S_NONE);
        for (int i = 0; i < ((waits >= WAIT_LIMIT) ? WAIT_LIMIT : waits); i++)
            add(st, base, 1'b0, r1(), r7());
        if (waits >= WAIT_LIMIT) begin
            add(3'd7, S_TO, r1(), r1(), r7());
            return 1'b1;
        end
        add(st, base | ((st == 3'd0) ? (S_IRL | S_PCI) : S_NONE), 1'b1, r1(), r7());
        return 1'b0;
    endfunction

    function automatic void build(input logic [6:0] fl, input logic z, input int fw, input int mw);
        if (mem_phase(3'd0, fw, 1'b0)) return;
        add(3'd1, S_NONE, r1(), r1(), fl);
        if ($countones(fl) != 1) begin
            add(3'd7, S_ILL, r1(), r1(), r7());
            return;
        end
        if (fl == F_POP) begin
            if (!mem_phase(3'd3, mw, 1'b0)) add(3'd4, S_RWE | S_SPI, r1(), r1(), r7());
            return;
        end
        case (fl)
            F_ALU: begin
                add(3'd2, S_NONE, r1(), r1(), r7());
                add(3'd4, S_RWE, r1(), r1(), r7());
            end
            F_LD: begin
                add(3'd2, S_NONE, r1(), r1(), r7());
                if (!mem_phase(3'd3, mw, 1'b0)) add(3'd4, S_RWE, r1(), r1(), r7());
            end
            F_ST: begin
                add(3'd2, S_NONE, r1(), r1(), r7());
                void'(mem_phase(3'd3, mw, 1'b1));
            end
            F_PUSH: begin
                add(3'd2, S_SPD, r1(), r1(), r7());
                void'(mem_phase(3'd3, mw, 1'b1));
            end
            F_JUMP:  add(3'd2, S_PCL, r1(), r1(), r7());
            default: add(3'd2, z ? S_PCL : S_NONE, r1(), z, r7());
        endcase
    endfunction

    task automatic check(input string tag, input logic [2:0] st, input logic [9:0] strb);
        logic [9:0] obs;
        obs = {bus.mem_req, bus.mem_we, bus.ir_load, bus.pc_inc, bus.pc_load,
               bus.sp_dec, bus.sp_inc, bus.reg_we, bus.illegal, bus.timeout};
        vectors++;
        assert (bus.state === st) else begin
            miscompares++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, bus.state, st);
        end
        vectors++;
        assert (obs === strb) else begin
            miscompares++;
            $error("FAIL %s strobes: observed=%b expected=%b (state %0d)", tag, obs, strb, st);
        end
    endtask

    // Called at a falling edge; drives each cycle's inputs, checks, then moves to the next falling edge.
    task automatic run_q(input string tag, input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) break;
            e = q.pop_front();
            {bus.be, bus.jump, bus.pop, bus.push, bus.st, bus.ld, bus.alu} = e.fl;
            bus.zero      = e.z;
            bus.mem_ready = e.rdy;
            #1;
            check(tag, e.st, e.strb);
            @(negedge clk);
        end
    endtask

    task automatic instr(input string tag, input logic [6:0] fl, input logic z, input int fw, input int mw);
        build(fl, z, fw, mw);
        run_q(tag, 1000);
    endtask

    initial begin
        logic [6:0] fl;
        int         fw, mw, pick;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        {bus.be, bus.jump, bus.pop, bus.push, bus.st, bus.ld, bus.alu} = 7'b000_0000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("reset", 3'd0, S_NONE);
        @(negedge clk);
        rst_n = 1'b1;

        instr("alu",       F_ALU,  1'b0, 0, 0);
        instr("ld_wait2",  F_LD,   1'b0, 0, 2);
        instr("push",      F_PUSH, 1'b0, 0, 0);
        instr("pop",       F_POP,  1'b0, 0, 0);
        instr("be_taken",  F_BE,   1'b1, 0, 0);
        instr("be_not",    F_BE,   1'b0, 0, 0);
        instr("jump",      F_JUMP, 1'b0, 1, 0);
        instr("st",        F_ST,   1'b0, 0, 1);
        instr("ill_two",   F_ALU | F_LD, 1'b0, 0, 0);
        instr("ill_none",  7'b000_0000,  1'b0, 0, 0);
        instr("st_tmo",    F_ST,   1'b0, 0, 20);
        instr("ld_edge14", F_LD,   1'b0, 0, 14);
        instr("fetch_14",  F_ALU,  1'b0, 14, 0);
        instr("fetch_tmo", F_ALU,  1'b0, 15, 0);
        instr("pop_tmo",   F_POP,  1'b0, 0, 15);

        // Reset asserted in the middle of a stalled store.
        build(F_ST, 1'b0, 0, 20);
        run_q("st_pre_rst", 6);
        q.delete();
        #2;
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst", 3'd0, S_NONE);
        @(negedge clk);
        #1;
        check("mid_rst_hold", 3'd0, S_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        instr("after_rst", F_ALU, 1'b0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 9);
            if (pick < 8) fl = 7'(7'b000_0001 << $urandom_range(0, 6));
            else          fl = r7();
            pick = $urandom_range(0, 9);
            fw = (pick < 7) ? $urandom_range(0, 3) : ((pick < 9) ? 14 : 15 + $urandom_range(0, 3));
            pick = $urandom_range(0, 9);
            mw = (pick < 7) ? $urandom_range(0, 3) : ((pick < 9) ? 14 : 15 + $urandom_range(0, 3));
            instr("rand", fl, r1(), fw, mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
